universal_shift_reg: RTL and testbench

Parametrised universal shift register, the next generation of the fixed 4-bit PIPO register. It supports parallel load, hold, logical/arithmetic shifts and rotates, with multi-step operations sequenced by a small FSM and start/busy/done handshake. It is used as a general data-staging and serialisation element in datapath and serial-link blocks.

---
 rtl/usr_pkg.sv | 32 +++
 rtl/usr_step.sv | 29 ++
 rtl/universal_shift_reg.sv | 145 ++++++++++++++
 tb/tb_universal_shift_reg.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/usr_pkg.sv
// Shared types and helpers for the universal shift register.
// Mode codes, FSM states and the step-count clamp.
package usr_pkg;

  typedef enum logic [2:0] {
    MODE_HOLD = 3'd0,
    MODE_LOAD = 3'd1,
    MODE_SHL  = 3'd2,
    MODE_SHR  = 3'd3,
    MODE_ROL  = 3'd4,
    MODE_ROR  = 3'd5,
    MODE_ASR  = 3'd6,
    MODE_RSVD = 3'd7
  } usr_mode_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } usr_state_e;

  // Steps requested beyond the register width are pointless, so cap them.
  function automatic int unsigned clamp_count(input int unsigned cnt,
                                              input int unsigned width);
    return (cnt > width) ? width : cnt;
  endfunction

  function automatic logic is_stepped(input usr_mode_e m);
    return (m == MODE_SHL) || (m == MODE_SHR) || (m == MODE_ROL) ||
           (m == MODE_ROR) || (m == MODE_ASR);
  endfunction

endpackage

// File: rtl/usr_step.sv
// Combinational single-step next-value logic for the universal shift register.
// Hold and the reserved code both keep the current contents.
module usr_step
  import usr_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  usr_mode_e          mode,
  input  logic [WIDTH-1:0]   po,
  input  logic               ser_in_lsb,
  input  logic               ser_in_msb,
  input  logic [WIDTH-1:0]   pi,
  output logic [WIDTH-1:0]   nxt
);

  always_comb begin
    nxt = po;
    case (mode)
      MODE_LOAD: nxt = pi;
      MODE_SHL:  nxt = {po[WIDTH-2:0], ser_in_lsb};
      MODE_SHR:  nxt = {ser_in_msb, po[WIDTH-1:1]};
      MODE_ROL:  nxt = {po[WIDTH-2:0], po[WIDTH-1]};
      MODE_ROR:  nxt = {po[0], po[WIDTH-1:1]};
      MODE_ASR:  nxt = {po[WIDTH-1], po[WIDTH-1:1]};
      default:   nxt = po;
    endcase
  end

endmodule

// File: rtl/universal_shift_reg.sv
// Universal shift register with start/busy/done sequencing of multi-step ops.
// Define USR_PARITY_EN to add a registered parity output tracking ^PO.
module universal_shift_reg
  import usr_pkg::*;
#(
  parameter  int WIDTH = 8,
  localparam int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [2:0]         mode,
  input  logic [CNT_W-1:0]   count,
  input  logic [WIDTH-1:0]   PI,
  input  logic               ser_in_lsb,
  input  logic               ser_in_msb,
  output logic [WIDTH-1:0]   PO,
  output logic               so_msb,
  output logic               so_lsb,
  output logic               busy,
  output logic               done
`ifdef USR_PARITY_EN
  ,output logic              parity
`endif
);

  usr_state_e         state_q, state_d;
  usr_mode_e          mode_q, mode_d;
  logic [CNT_W-1:0]   rem_q, rem_d;
  logic [WIDTH-1:0]   po_q, po_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  usr_mode_e          mode_in;
  usr_mode_e          step_mode;
  logic [CNT_W-1:0]   n_eff;
  logic [WIDTH-1:0]   step_nxt;

  assign mode_in = usr_mode_e'(mode);
  assign n_eff   = CNT_W'(clamp_count(32'(count), WIDTH));

  // In IDLE the live mode drives the step so the first step lands on the start edge.
  assign step_mode = (state_q == ST_RUN) ? mode_q : mode_in;

  usr_step #(
    .WIDTH(WIDTH)
  ) u_step (
    .mode       (step_mode),
    .po         (po_q),
    .ser_in_lsb (ser_in_lsb),
    .ser_in_msb (ser_in_msb),
    .pi         (PI),
    .nxt        (step_nxt)
  );

  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    rem_d   = rem_q;
    po_d    = po_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (is_stepped(mode_in)) begin
            if (n_eff == '0) begin
              done_d = 1'b1;
            end else begin
              po_d = step_nxt;
              if (n_eff == CNT_W'(1)) begin
                done_d = 1'b1;
              end else begin
                state_d = ST_RUN;
                mode_d  = mode_in;
                rem_d   = n_eff - CNT_W'(1);
                busy_d  = 1'b1;
              end
            end
          end else begin
            // LOAD takes PI; HOLD and the reserved code leave PO as is.
            po_d   = step_nxt;
            done_d = 1'b1;
          end
        end
      end
      ST_RUN: begin
        po_d = step_nxt;
        if (rem_q == CNT_W'(1)) begin
          state_d = ST_IDLE;
          rem_d   = '0;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end else begin
          rem_d = rem_q - CNT_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      mode_q  <= MODE_HOLD;
      rem_q   <= '0;
      po_q    <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      rem_q   <= rem_d;
      po_q    <= po_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

`ifdef USR_PARITY_EN
  logic parity_q, parity_d;

  assign parity_d = ^po_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      parity_q <= 1'b0;
    end else begin
      parity_q <= parity_d;
    end
  end

  assign parity = parity_q;
`endif

  assign PO     = po_q;
  assign so_msb = po_q[WIDTH-1];
  assign so_lsb = po_q[0];
  assign busy   = busy_q;
  assign done   = done_q;

endmodule

// File: tb/tb_universal_shift_reg.sv
// Scoreboard bench for universal_shift_reg: stimulus queues expected results,
// a negedge monitor checks PO and busy length on every done pulse.
module tb_universal_shift_reg;
  import usr_pkg::*;

  localparam int WIDTH = 8;
  localparam int CNT_W = $clog2(WIDTH + 1);

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic [2:0]       mode;
  logic [CNT_W-1:0] count;
  logic [WIDTH-1:0] PI;
  logic             ser_in_lsb;
  logic             ser_in_msb;
  logic [WIDTH-1:0] PO;
  logic             so_msb;
  logic             so_lsb;
  logic             busy;
  logic             done;
`ifdef USR_PARITY_EN
  logic             parity;
`endif

  universal_shift_reg #(.WIDTH(WIDTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .mode       (mode),
    .count      (count),
    .PI         (PI),
    .ser_in_lsb (ser_in_lsb),
    .ser_in_msb (ser_in_msb),
    .PO         (PO),
    .so_msb     (so_msb),
    .so_lsb     (so_lsb),
    .busy       (busy),
    .done       (done)
`ifdef USR_PARITY_EN
    ,.parity    (parity)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    string            name;
    logic [WIDTH-1:0] po;
    int               busy_cycles;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;
  int   done_cnt = 0;
  int   busy_run = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end else begin
      $display("ok   %s: %0h", name, act);
    end
  endtask

  // Monitor: counts busy cycles and retires one expectation per done pulse.
  always @(negedge clk) begin
    if (rst) begin
      busy_run = 0;
    end else begin
      if (busy) busy_run++;
      if (done) begin
        done_cnt++;
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_done: got done=1 PO=%0h expected no done", PO);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk({e.name, "_po"}, 32'(PO), 32'(e.po));
          chk({e.name, "_busy"}, 32'(busy_run), 32'(e.busy_cycles));
          chk({e.name, "_so"}, {30'd0, so_msb, so_lsb}, {30'd0, e.po[WIDTH-1], e.po[0]});
        end
        busy_run = 0;
      end
    end
  end

  task automatic issue(input string name, input logic [2:0] m, input int c,
                       input logic [WIDTH-1:0] p, input logic [WIDTH-1:0] epo,
                       input int eb);
    exp_t e;
    @(negedge clk);
    mode  = m;
    count = CNT_W'(c);
    PI    = p;
    start = 1'b1;
    e.name = name;
    e.po = epo;
    e.busy_cycles = eb;
    exp_q.push_back(e);
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic wait_done(input string name, input int base);
    int waited;
    waited = 0;
    while (done_cnt == base && waited < 40) begin
      @(negedge clk);
      #1;
      waited++;
    end
    if (done_cnt == base) begin
      total++;
      bad++;
      $display("FAIL %s_timeout: got no done after %0d cycles expected done", name, waited);
    end
  endtask

  task automatic op(input string name, input logic [2:0] m, input int c,
                    input logic [WIDTH-1:0] p, input logic [WIDTH-1:0] epo,
                    input int eb);
    int base;
    base = done_cnt;
    issue(name, m, c, p, epo, eb);
    wait_done(name, base);
  endtask

  initial begin
    int base;
    rst = 1'b1; start = 1'b0; mode = 3'd0; count = '0; PI = '0;
    ser_in_lsb = 1'b0; ser_in_msb = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_po", 32'(PO), 32'h00);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_done", 32'(done), 32'd0);
    rst = 1'b0;

    op("load_a5", MODE_LOAD, 0, 8'hA5, 8'hA5, 0);
`ifdef USR_PARITY_EN
    chk("parity_a5", 32'(parity), 32'd0);
`endif

    // SHL x3 with ser_in_lsb=1, checking each step.
    ser_in_lsb = 1'b1;
    base = done_cnt;
    issue("shl3", MODE_SHL, 3, 8'h00, 8'h2F, 2);
    @(negedge clk); #1;
    chk("shl3_step1", 32'(PO), 32'h4B);
    chk("shl3_busy1", 32'(busy), 32'd1);
    @(negedge clk); #1;
    chk("shl3_step2", 32'(PO), 32'h97);
`ifdef USR_PARITY_EN
    chk("parity_97", 32'(parity), 32'd1);
`endif
    wait_done("shl3", base);

    op("ror4", MODE_ROR, 4, 8'h00, 8'hF2, 3);
    op("ror8", MODE_ROR, 8, 8'h00, 8'hF2, 7);
    op("rol1", MODE_ROL, 1, 8'h00, 8'hE5, 0);
    op("hold", MODE_HOLD, 3, 8'h11, 8'hE5, 0);
    op("rsvd", MODE_RSVD, 3, 8'h22, 8'hE5, 0);

    op("load_90", MODE_LOAD, 0, 8'h90, 8'h90, 0);
    op("asr2", MODE_ASR, 2, 8'h00, 8'hE4, 1);
    op("load_ff", MODE_LOAD, 0, 8'hFF, 8'hFF, 0);
    ser_in_msb = 1'b0;
    op("shr9", MODE_SHR, 9, 8'h00, 8'h00, 7);

    // SHL x5 with a LOAD start pulsed while busy; it must be ignored.
    op("load_a5b", MODE_LOAD, 0, 8'hA5, 8'hA5, 0);
    base = done_cnt;
    issue("shl5", MODE_SHL, 5, 8'h00, 8'hBF, 4);
    @(negedge clk);
    mode = MODE_LOAD; PI = 8'h3C; count = CNT_W'(1); start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    wait_done("shl5", base);

    // Reset after the second step of a repeat: no done, PO cleared.
    op("load_a5c", MODE_LOAD, 0, 8'hA5, 8'hA5, 0);
    @(negedge clk);
    mode = MODE_SHL; count = CNT_W'(5); start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("shl5r_step2", 32'(PO), 32'h97);
    rst = 1'b1;
    @(negedge clk); #1;
    chk("midrst_po", 32'(PO), 32'h00);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_done", 32'(done), 32'd0);
    rst = 1'b0;
    repeat (6) @(negedge clk);
    op("load_3c", MODE_LOAD, 0, 8'h3C, 8'h3C, 0);

    op("load_a5d", MODE_LOAD, 0, 8'hA5, 8'hA5, 0);
    op("shl0", MODE_SHL, 0, 8'h00, 8'hA5, 0);

    repeat (4) @(negedge clk);
    chk("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
